// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction bus with a
// hold-until-response handshake, and feeds the fetch/decode register through a one-entry skid.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   S_REQ     | request at pc outstanding on the bus (after the first cycle out of reset)
//   S_FULL    | fd held by stall and skid occupied; no bus request
//   S_DISCARD | redirect seen mid-request; old request held, its data dropped
module fetch_stage #(
   parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        fd_valid,
   output logic [63:0] fd_pc,
   output logic [31:0] fd_raw_instr
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_FULL    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic        run, run_nx;
   logic [63:0] pc, pc_nx;
   logic [63:0] pend_pc, pend_pc_nx;
   logic        skid_valid, skid_valid_nx;
   logic [63:0] skid_pc, skid_pc_nx;
   logic [31:0] skid_instr, skid_instr_nx;
   logic        fd_valid_nx;
   logic [63:0] fd_pc_nx;
   logic [31:0] fd_instr_nx;

   logic        accept;
   logic        fd_free;
   logic [63:0] redirect_tgt;
   logic [63:0] pc_inc;

   // run holds the bus quiet for the first cycle out of reset
   assign ireq_valid   = run && (state != S_FULL);
   assign ireq_addr    = pc;
   assign accept       = ireq_valid && iresp_data_ok;
   assign fd_free      = !fd_valid || !stall;
   assign redirect_tgt = redirect_pc & ~64'h3;
   assign pc_inc       = pc + 64'd4;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_REQ;
         run          <= 1'b0;
         pc           <= PC_RESET;
         pend_pc      <= 64'd0;
         skid_valid   <= 1'b0;
         skid_pc      <= 64'd0;
         skid_instr   <= 32'd0;
         fd_valid     <= 1'b0;
         fd_pc        <= 64'd0;
         fd_raw_instr <= 32'd0;
      end else begin
         state        <= state_nx;
         run          <= run_nx;
         pc           <= pc_nx;
         pend_pc      <= pend_pc_nx;
         skid_valid   <= skid_valid_nx;
         skid_pc      <= skid_pc_nx;
         skid_instr   <= skid_instr_nx;
         fd_valid     <= fd_valid_nx;
         fd_pc        <= fd_pc_nx;
         fd_raw_instr <= fd_instr_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      run_nx        = 1'b1;
      pc_nx         = pc;
      pend_pc_nx    = pend_pc;
      skid_valid_nx = skid_valid;
      skid_pc_nx    = skid_pc;
      skid_instr_nx = skid_instr;
      fd_valid_nx   = fd_valid;
      fd_pc_nx      = fd_pc;
      fd_instr_nx   = fd_raw_instr;

      if (redirect_valid) begin
         fd_valid_nx   = 1'b0;
         skid_valid_nx = 1'b0;
         // with a request still in flight the new target must wait for its response
         if (!ireq_valid || accept) begin
            pc_nx    = redirect_tgt;
            state_nx = S_REQ;
         end else begin
            pend_pc_nx = redirect_tgt;
            state_nx   = S_DISCARD;
         end
      end else begin
         unique case (state)
            S_REQ: begin
               if (accept) begin
                  pc_nx = pc_inc;
                  if (fd_free) begin
                     fd_valid_nx = 1'b1;
                     fd_pc_nx    = pc;
                     fd_instr_nx = iresp_data;
                  end else begin
                     skid_valid_nx = 1'b1;
                     skid_pc_nx    = pc;
                     skid_instr_nx = iresp_data;
                     state_nx      = S_FULL;
                  end
               end else if (!stall) begin
                  fd_valid_nx = 1'b0;
               end
            end
            S_FULL: begin
               if (!stall) begin
                  fd_valid_nx   = skid_valid;
                  fd_pc_nx      = skid_pc;
                  fd_instr_nx   = skid_instr;
                  skid_valid_nx = 1'b0;
                  state_nx      = S_REQ;
               end
            end
            S_DISCARD: begin
               if (accept) begin
                  pc_nx    = pend_pc;
                  state_nx = S_REQ;
               end
               if (!stall) begin
                  fd_valid_nx = 1'b0;
               end
            end
            default: state_nx = S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-FULL sequence, then
// randomized bus/stall/redirect traffic against a queue-based reference model.
module tb_fetch_stage;

   localparam logic [63:0] PC_RESET = 64'h8000_0000;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        fd_valid;
   logic [63:0] fd_pc;
   logic [31:0] fd_raw_instr;

   int n_vec = 0;
   int n_bad = 0;

   fetch_stage #(.PC_RESET(PC_RESET)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fd_valid       (fd_valid),
      .fd_pc          (fd_pc),
      .fd_raw_instr   (fd_raw_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dok;
      logic [31:0] data;
      logic        stl;
      logic        rv;
      logic [63:0] rpc;
      logic        e_iv;
      logic [63:0] e_addr;
      logic        e_fv;
      logic [63:0] e_fpc;
      logic [31:0] e_fin;
   } vec_t;

   function automatic vec_t mk(logic dok, logic [31:0] data, logic stl, logic rv,
                               logic [63:0] rpc, logic e_iv, logic [63:0] e_addr,
                               logic e_fv, logic [63:0] e_fpc, logic [31:0] e_fin);
      vec_t v;
      v.dok = dok; v.data = data; v.stl = stl; v.rv = rv; v.rpc = rpc;
      v.e_iv = e_iv; v.e_addr = e_addr; v.e_fv = e_fv; v.e_fpc = e_fpc; v.e_fin = e_fin;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic dok, logic [31:0] data, logic stl, logic rv, logic [63:0] rpc);
      iresp_data_ok  = dok;
      iresp_data     = data;
      stall          = stl;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   // Reference model: m_q[0] is what decode sees, m_q[1] is the word parked behind it.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        m_q[$];
   logic [63:0] m_pc;
   logic [63:0] m_pend;
   bit          m_disc;
   bit          m_started;
   logic [63:0] m_last_pc;
   logic [31:0] m_last_in;

   function automatic bit m_bus_active();
      return m_started && (m_q.size() < 2);
   endfunction

   task automatic model_step(logic dok, logic [31:0] d, logic st, logic rv, logic [63:0] rp);
      bit          active;
      logic [63:0] t;
      ent_t        e;
      active = m_bus_active();
      t = {rp[63:2], 2'b00};
      if (rv) begin
         m_q.delete();
         if (!active || dok) begin
            m_pc   = t;
            m_disc = 0;
         end else begin
            m_pend = t;
            m_disc = 1;
         end
      end else if (active && dok) begin
         if (m_disc) begin
            m_pc   = m_pend;
            m_disc = 0;
         end else begin
            if (!st && m_q.size() > 0) void'(m_q.pop_front());
            e.pc  = m_pc;
            e.ins = d;
            m_q.push_back(e);
            m_pc = m_pc + 64'd4;
         end
      end else if (!st && m_q.size() > 0) begin
         void'(m_q.pop_front());
      end
      m_started = 1;
      if (m_q.size() > 0) begin
         m_last_pc = m_q[0].pc;
         m_last_in = m_q[0].ins;
      end
   endtask

   vec_t vt[24];

   initial begin
      logic        r_dok, r_stl, r_rv, e_iv;
      logic [31:0] r_data;
      logic [63:0] r_rpc;

      vt[0]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 64'h0,                   1'b1, 64'h8000_0000, 1'b0, 64'h0,          32'h0);
      vt[1]  = mk(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 32'h0000_0013);
      vt[2]  = mk(1'b1, 32'h0010_0093, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h0010_0093);
      vt[3]  = mk(1'b1, 32'h0020_0113, 1'b1, 1'b0, 64'h0,                  1'b0, 64'h0,         1'b1, 64'h8000_0004, 32'h0010_0093);
      vt[4]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 64'h0,                   1'b0, 64'h0,         1'b1, 64'h8000_0004, 32'h0010_0093);
      vt[5]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 64'h0,                   1'b0, 64'h0,         1'b1, 64'h8000_0004, 32'h0010_0093);
      vt[6]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 64'h0,                   1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008, 32'h0020_0113);
      vt[7]  = mk(1'b1, 32'h0030_0193, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C, 32'h0030_0193);
      vt[8]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 64'h8000_0100,           1'b1, 64'h8000_0010, 1'b0, 64'h8000_000C, 32'h0030_0193);
      vt[9]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 64'h0,                   1'b1, 64'h8000_0010, 1'b0, 64'h8000_000C, 32'h0030_0193);
      vt[10] = mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0100, 1'b0, 64'h8000_000C, 32'h0030_0193);
      vt[11] = mk(1'b1, 32'h0040_0213, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0104, 1'b1, 64'h8000_0100, 32'h0040_0213);
      vt[12] = mk(1'b1, 32'hCAFE_BABE, 1'b1, 1'b1, 64'h8000_0200,          1'b1, 64'h8000_0200, 1'b0, 64'h8000_0100, 32'h0040_0213);
      vt[13] = mk(1'b1, 32'h0050_0293, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0204, 1'b1, 64'h8000_0200, 32'h0050_0293);
      vt[14] = mk(1'b0, 32'h0,        1'b0, 1'b1, 64'h8000_0300,           1'b1, 64'h8000_0204, 1'b0, 64'h8000_0200, 32'h0050_0293);
      vt[15] = mk(1'b0, 32'h0,        1'b0, 1'b1, 64'h8000_0400,           1'b1, 64'h8000_0204, 1'b0, 64'h8000_0200, 32'h0050_0293);
      vt[16] = mk(1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0400, 1'b0, 64'h8000_0200, 32'h0050_0293);
      vt[17] = mk(1'b1, 32'h0060_0313, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8000_0404, 1'b1, 64'h8000_0400, 32'h0060_0313);
      vt[18] = mk(1'b1, 32'h2222_2222, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h8000_0400, 32'h0060_0313);
      vt[19] = mk(1'b1, 32'h0070_0393, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h0,         1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0070_0393);
      vt[20] = mk(1'b1, 32'h0080_0413, 1'b1, 1'b0, 64'h0,                  1'b0, 64'h0,         1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0070_0393);
      vt[21] = mk(1'b0, 32'h0,        1'b1, 1'b1, 64'h8000_0500,           1'b1, 64'h8000_0500, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0070_0393);
      vt[22] = mk(1'b1, 32'h0090_0493, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h8000_0504, 1'b1, 64'h8000_0500, 32'h0090_0493);
      vt[23] = mk(1'b1, 32'h00A0_0513, 1'b1, 1'b0, 64'h0,                  1'b0, 64'h0,         1'b1, 64'h8000_0500, 32'h0090_0493);

      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      repeat (3) @(negedge clk);
      chk("rst ireq_valid", 64'(ireq_valid), 64'h0);
      chk("rst ireq_addr", ireq_addr, PC_RESET);
      chk("rst fd_valid", 64'(fd_valid), 64'h0);
      chk("rst fd_pc", fd_pc, 64'h0);
      chk("rst fd_raw_instr", 64'(fd_raw_instr), 64'h0);
      reset = 1'b1;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         drive(vt[i].dok, vt[i].data, vt[i].stl, vt[i].rv, vt[i].rpc);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d ireq_valid", i), 64'(ireq_valid), 64'(vt[i].e_iv));
         if (vt[i].e_iv) chk($sformatf("v%0d ireq_addr", i), ireq_addr, vt[i].e_addr);
         chk($sformatf("v%0d fd_valid", i), 64'(fd_valid), 64'(vt[i].e_fv));
         chk($sformatf("v%0d fd_pc", i), fd_pc, vt[i].e_fpc);
         chk($sformatf("v%0d fd_raw_instr", i), 64'(fd_raw_instr), 64'(vt[i].e_fin));
      end

      // reset pulled mid-cycle while FULL and stalled: outputs must clear at once
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst ireq_valid", 64'(ireq_valid), 64'h0);
      chk("midrst ireq_addr", ireq_addr, PC_RESET);
      chk("midrst fd_valid", 64'(fd_valid), 64'h0);
      chk("midrst fd_pc", fd_pc, 64'h0);
      chk("midrst fd_raw_instr", 64'(fd_raw_instr), 64'h0);
      repeat (2) @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("restart ireq_valid", 64'(ireq_valid), 64'h1);
      chk("restart ireq_addr", ireq_addr, PC_RESET);
      chk("restart fd_valid", 64'(fd_valid), 64'h0);

      m_q.delete();
      m_pc      = PC_RESET;
      m_pend    = 64'h0;
      m_disc    = 0;
      m_started = 1;
      m_last_pc = 64'h0;
      m_last_in = 32'h0;

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         r_dok  = ireq_valid ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
         r_data = $urandom;
         r_stl  = ($urandom_range(0, 2) == 0);
         r_rv   = ($urandom_range(0, 11) == 0);
         r_rpc  = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                             : {$urandom, $urandom};
         drive(r_dok, r_data, r_stl, r_rv, r_rpc);
         @(posedge clk);
         model_step(r_dok, r_data, r_stl, r_rv, r_rpc);
         #1;
         e_iv = m_bus_active();
         chk($sformatf("rnd%0d ireq_valid", c), 64'(ireq_valid), 64'(e_iv));
         if (e_iv) chk($sformatf("rnd%0d ireq_addr", c), ireq_addr, m_pc);
         chk($sformatf("rnd%0d fd_valid", c), 64'(fd_valid), 64'(m_q.size() > 0));
         chk($sformatf("rnd%0d fd_pc", c), fd_pc, m_last_pc);
         chk($sformatf("rnd%0d fd_raw_instr", c), 64'(fd_raw_instr), 64'(m_last_in));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
